// File: rtl/nbit_demux_router.sv
// nbit_demux_router: 1-to-CH registered demux feeding a 2-deep buffer per channel.
// Optional DEMUX_BROADCAST_EN adds in_bcast to push one word into every channel.
module nbit_demux_router #(
  parameter int N = 32,
  parameter int CH = 4,
  localparam int SELW = $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    in_data,
  input  logic [SELW-1:0] in_sel,
  input  logic            in_valid,
`ifdef DEMUX_BROADCAST_EN
  input  logic            in_bcast,
`endif
  output logic            in_ready,
  output logic [CH*N-1:0] out_data,
  output logic [CH-1:0]   out_valid,
  input  logic [CH-1:0]   out_ready,
  output logic            err_sel
);
  logic bcast;
  logic sel_ok;
  logic acc;
  logic [CH-1:0] full;
`ifdef DEMUX_BROADCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif
  assign sel_ok = 32'(in_sel) < CH;
  // ready comes only from registered counts, never from out_ready
  assign in_ready = bcast ? ~|full : (!sel_ok || !full[in_sel]);
  assign acc = in_valid & in_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_sel <= 1'b0;
    else if (acc && !bcast && !sel_ok) err_sel <= 1'b1;
  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic [1:0] cnt;
    logic [N-1:0] head, tail;
    logic push, pop;
    assign push = acc & (bcast | (sel_ok & (in_sel == SELW'(k))));
    assign pop = out_valid[k] & out_ready[k];
    assign full[k] = cnt == 2'd2;
    assign out_valid[k] = cnt != 2'd0;
    assign out_data[k*N +: N] = head;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        cnt <= 2'd0;
        head <= '0;
        tail <= '0;
      end else if (push && (cnt == 2'd0 || pop)) begin
        head <= in_data;
        cnt <= 2'd1;
      end else if (push) begin
        tail <= in_data;
        cnt <= 2'd2;
      end else if (pop && cnt == 2'd2) begin
        head <= tail;
        cnt <= 2'd1;
      end else if (pop) begin
        cnt <= 2'd0;
      end
  end
endmodule

// File: tb/tb_nbit_demux_router.sv
// tb_nbit_demux_router: queue-model bench for nbit_demux_router (CH=4 main, CH=3 out-of-range).
module tb_nbit_demux_router;
  logic clk = 0, rst_n = 0;
  logic [31:0] in_data = 0;
  logic [1:0] in_sel = 0;
  logic in_valid = 0, in_ready;
  logic [127:0] out_data;
  logic [3:0] out_valid, out_ready = 0;
  logic err_sel;
  logic [31:0] a_data = 0;
  logic [1:0] a_sel = 0;
  logic a_valid = 0, a_ready;
  logic [95:0] a_odata;
  logic [2:0] a_ovalid, a_oready = 0;
  logic a_err;
`ifdef DEMUX_BROADCAST_EN
  logic in_bcast = 0, a_bcast = 0;
`endif
  int checks = 0, failures = 0;
  bit [31:0] mq [4][$];
  bit [31:0] mlast [4];
  always #5 clk = ~clk;
  nbit_demux_router #(.N(32), .CH(4)) d4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
`ifdef DEMUX_BROADCAST_EN
    .in_bcast(in_bcast),
`endif
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .err_sel(err_sel));
  nbit_demux_router #(.N(32), .CH(3)) d3 (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_sel(a_sel), .in_valid(a_valid),
`ifdef DEMUX_BROADCAST_EN
    .in_bcast(a_bcast),
`endif
    .in_ready(a_ready), .out_data(a_odata), .out_valid(a_ovalid),
    .out_ready(a_oready), .err_sel(a_err));
  function automatic bit bc();
`ifdef DEMUX_BROADCAST_EN
    return in_bcast;
`else
    return 1'b0;
`endif
  endfunction
  // model: each channel is a queue of capacity 2
  function automatic bit mready();
    if (bc()) begin
      for (int k = 0; k < 4; k++) if (mq[k].size() >= 2) return 1'b0;
      return 1'b1;
    end
    return mq[in_sel].size() < 2;
  endfunction
  task automatic mreset();
    for (int k = 0; k < 4; k++) begin
      mq[k].delete();
      mlast[k] = 0;
    end
  endtask
  task automatic step();
    bit acc;
    bit [3:0] pop;
    acc = in_valid && mready();
    for (int k = 0; k < 4; k++) pop[k] = mq[k].size() != 0 && out_ready[k];
    @(posedge clk);
    for (int k = 0; k < 4; k++) if (pop[k]) void'(mq[k].pop_front());
    if (acc) for (int k = 0; k < 4; k++) if (bc() || in_sel == 2'(k)) mq[k].push_back(in_data);
    for (int k = 0; k < 4; k++) if (mq[k].size() != 0) mlast[k] = mq[k][0];
    #1;
  endtask
  task automatic drain();
    in_valid = 0;
    out_ready = 4'hf;
    repeat (3) step();
    out_ready = 0;
  endtask
  task automatic test_reset();
    rst_n = 0;
    in_valid = 1;
    in_sel = 2;
    in_data = $urandom;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 4'b0 || err_sel !== 1'b0 || out_data !== 128'b0 || a_err !== 1'b0) begin
      failures++;
      $display("FAIL reset: out_valid=%b err_sel=%b out_data=%h a_err=%b want 0", out_valid, err_sel, out_data, a_err);
    end
    rst_n = 1;
    in_data = 32'hA5A5A5A5;
    step();
    in_valid = 0;
    checks++;
    if (out_valid !== 4'b0100 || out_data[64 +: 32] !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL first_push: out_valid=%b slice2=%h want 0100 a5a5a5a5", out_valid, out_data[64 +: 32]);
    end
    drain();
  endtask
  task automatic test_backpressure();
    out_ready = 0;
    in_valid = 1;
    in_sel = 1;
    in_data = 32'h11;
    step();
    in_data = 32'h22;
    step();
    in_valid = 0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_ready_sel1: in_ready=%b want 0", in_ready);
    end
    in_sel = 0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_ready_sel0: in_ready=%b want 1", in_ready);
    end
    out_ready = 4'b0010;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (out_valid[1] !== 1'b1 || out_data[32 +: 32] !== 32'(i + 1) * 32'h11) begin
        failures++;
        $display("FAIL bp_order%0d: valid=%b data=%h want 1 %h", i, out_valid[1], out_data[32 +: 32], 32'(i + 1) * 32'h11);
      end
      step();
    end
    checks++;
    if (out_valid[1] !== 1'b0 || out_data[32 +: 32] !== 32'h22) begin
      failures++;
      $display("FAIL bp_empty: valid=%b data=%h want 0 22", out_valid[1], out_data[32 +: 32]);
    end
    out_ready = 0;
  endtask
  task automatic test_stream();
    out_ready = 4'b1000;
    in_sel = 3;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1;
      in_data = 32'(i);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL stream_ready%0d: in_ready=%b want 1", i, in_ready);
      end
      step();
      checks++;
      if (out_valid[3] !== 1'b1 || out_data[96 +: 32] !== 32'(i)) begin
        failures++;
        $display("FAIL stream%0d: valid=%b data=%h want 1 %h", i, out_valid[3], out_data[96 +: 32], i);
      end
    end
    in_valid = 0;
    step();
    checks++;
    if (out_valid[3] !== 1'b0) begin
      failures++;
      $display("FAIL stream_end: valid=%b want 0", out_valid[3]);
    end
    out_ready = 0;
  endtask
  task automatic test_parallel();
    out_ready = 0;
    in_valid = 1;
    in_sel = 0;
    in_data = 32'h10;
    step();
    in_sel = 2;
    in_data = 32'h20;
    step();
    in_valid = 0;
    checks++;
    if (out_valid !== 4'b0101 || out_data[0 +: 32] !== 32'h10 || out_data[64 +: 32] !== 32'h20) begin
      failures++;
      $display("FAIL par_fill: valid=%b s0=%h s2=%h want 0101 10 20", out_valid, out_data[0 +: 32], out_data[64 +: 32]);
    end
    out_ready = 4'hf;
    step();
    checks++;
    if (out_valid !== 4'b0) begin
      failures++;
      $display("FAIL par_drain: valid=%b want 0000", out_valid);
    end
    out_ready = 0;
  endtask
  task automatic test_out_of_range();
    in_valid = 0;
    a_sel = 3;
    a_data = 32'hDEAD;
    a_valid = 1;
    #1;
    checks++;
    if (a_ready !== 1'b1) begin
      failures++;
      $display("FAIL oor_ready: in_ready=%b want 1", a_ready);
    end
    step();
    a_valid = 0;
    checks++;
    if (a_ovalid !== 3'b0 || a_err !== 1'b1) begin
      failures++;
      $display("FAIL oor_drop: out_valid=%b err=%b want 000 1", a_ovalid, a_err);
    end
    repeat (2) step();
    checks++;
    if (a_err !== 1'b1) begin
      failures++;
      $display("FAIL oor_sticky: err=%b want 1", a_err);
    end
    a_sel = 0;
    a_data = 32'h1234;
    a_valid = 1;
    in_valid = 1;
    in_sel = 1;
    in_data = 32'h55;
    step();
    a_valid = 0;
    in_valid = 0;
    checks++;
    if (a_ovalid !== 3'b001 || a_odata[31:0] !== 32'h1234 || out_valid !== 4'b0010) begin
      failures++;
      $display("FAIL pre_reset: a_valid=%b a_s0=%h valid=%b want 001 1234 0010", a_ovalid, a_odata[31:0], out_valid);
    end
    #2 rst_n = 0;
    #1;
    mreset();
    checks++;
    if (a_ovalid !== 3'b0 || a_err !== 1'b0 || a_odata !== 96'b0 || out_valid !== 4'b0 || out_data !== 128'b0) begin
      failures++;
      $display("FAIL async_reset: a_valid=%b a_err=%b a_data=%h valid=%b want all 0", a_ovalid, a_err, a_odata, out_valid);
    end
    #1 rst_n = 1;
  endtask
`ifdef DEMUX_BROADCAST_EN
  task automatic test_broadcast();
    drain();
    in_valid = 1;
    in_sel = 0;
    in_data = 32'hB1;
    step();
    in_data = 32'hB2;
    step();
    in_bcast = 1;
    in_sel = 2;
    in_data = 32'h77;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bcast_blocked: in_ready=%b want 0", in_ready);
    end
    out_ready = 4'b0001;
    step();
    out_ready = 0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bcast_ready: in_ready=%b want 1", in_ready);
    end
    step();
    in_valid = 0;
    in_bcast = 0;
    checks++;
    if (out_valid !== 4'hf || out_data !== {32'h77, 32'h77, 32'h77, 32'hB2} || err_sel !== 1'b0) begin
      failures++;
      $display("FAIL bcast_push: valid=%b data=%h err=%b want f 77/77/77/b2 0", out_valid, out_data, err_sel);
    end
    out_ready = 4'b0001;
    step();
    out_ready = 0;
    checks++;
    if (out_data[31:0] !== 32'h77) begin
      failures++;
      $display("FAIL bcast_ch0: data=%h want 77", out_data[31:0]);
    end
  endtask
`endif
  task automatic test_random();
    repeat (400) begin
      in_valid = 1'($urandom_range(0, 1));
      in_sel = 2'($urandom);
      in_data = $urandom;
      out_ready = 4'($urandom);
`ifdef DEMUX_BROADCAST_EN
      in_bcast = $urandom_range(0, 7) == 0;
`endif
      #1;
      checks++;
      if (in_ready !== mready()) begin
        failures++;
        $display("FAIL rnd_ready: in_ready=%b want %b", in_ready, mready());
      end
      step();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (out_valid[k] !== (mq[k].size() != 0) || out_data[k*32 +: 32] !== mlast[k]) begin
          failures++;
          $display("FAIL rnd_ch%0d: valid=%b data=%h want %b %h", k, out_valid[k], out_data[k*32 +: 32], mq[k].size() != 0, mlast[k]);
        end
      end
    end
    in_valid = 0;
    checks++;
    if (err_sel !== 1'b0) begin
      failures++;
      $display("FAIL rnd_err: err_sel=%b want 0", err_sel);
    end
  endtask
  initial begin
    test_reset();
    test_backpressure();
    test_stream();
    test_parallel();
    test_out_of_range();
`ifdef DEMUX_BROADCAST_EN
    test_broadcast();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded budget");
    $fatal(1);
  end
endmodule
